// File: rtl/aiken_pkg.sv
// Shared Aiken (2421) code constants and digit type for the Aiken decoder slice.
package aiken_pkg;

    typedef logic [3:0] aik_digit_t;

    localparam aik_digit_t AIK_0 = 4'b0000;
    localparam aik_digit_t AIK_1 = 4'b0001;
    localparam aik_digit_t AIK_2 = 4'b0010;
    localparam aik_digit_t AIK_3 = 4'b0011;
    localparam aik_digit_t AIK_4 = 4'b0100;
    localparam aik_digit_t AIK_5 = 4'b1011;
    localparam aik_digit_t AIK_6 = 4'b1100;
    localparam aik_digit_t AIK_7 = 4'b1101;
    localparam aik_digit_t AIK_8 = 4'b1110;
    localparam aik_digit_t AIK_9 = 4'b1111;

    localparam aik_digit_t AIK_BIN_INVALID = 4'd0;

endpackage

// File: rtl/aik_2_b_lut.sv
// Combinational Aiken (2421) to binary decode; usable unclocked on its own.
module aik_2_b_lut
    import aiken_pkg::*;
(
    input  logic [3:0] aiken,
    output logic [3:0] bin_c,
    output logic       invalid_c
);

    always_comb begin
        bin_c     = AIK_BIN_INVALID;
        invalid_c = 1'b0;
        case (aiken)
            AIK_0:   bin_c = 4'd0;
            AIK_1:   bin_c = 4'd1;
            AIK_2:   bin_c = 4'd2;
            AIK_3:   bin_c = 4'd3;
            AIK_4:   bin_c = 4'd4;
            AIK_5:   bin_c = 4'd5;
            AIK_6:   bin_c = 4'd6;
            AIK_7:   bin_c = 4'd7;
            AIK_8:   bin_c = 4'd8;
            AIK_9:   bin_c = 4'd9;
            // 0101..1010 are the six unused 2421 patterns
            default: invalid_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/aik_2_b.sv
// Aiken (2421) to binary decoder with one-cycle registered bin/invalid outputs.
module aik_2_b
    import aiken_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] aiken,
    output logic [3:0] bin,
    output logic       invalid
);

    logic [3:0] w_bin_c;
    logic       w_invalid_c;
    logic [3:0] r_bin;
    logic       r_invalid;

    aik_2_b_lut u_lut (
        .aiken     (aiken),
        .bin_c     (w_bin_c),
        .invalid_c (w_invalid_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin     <= AIK_BIN_INVALID;
            r_invalid <= 1'b0;
        end else begin
            r_bin     <= w_bin_c;
            r_invalid <= w_invalid_c;
        end
    end

    assign bin     = r_bin;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_aik_2_b.sv
// Self-checking bench for aik_2_b: weighted-sum reference model plus directed literal checks.
module tb_aik_2_b;

    logic       clk;
    logic       rst;
    logic [3:0] aiken;
    logic [3:0] bin;
    logic       invalid;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_bin;
    logic       exp_inv;

    aik_2_b dut (
        .clk     (clk),
        .rst     (rst),
        .aiken   (aiken),
        .bin     (bin),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weighted value 2,4,2,1; a code is legal only if it equals the
    // canonical Aiken spelling of that value (d for d<5, d+6 for d>=5).
    function automatic logic [4:0] model(input logic [3:0] c);
        int w;
        int canon;
        w     = 2 * c[3] + 4 * c[2] + 2 * c[1] + c[0];
        canon = (w < 5) ? w : w + 6;
        if (canon == int'(c)) return {1'b0, 4'(w)};
        return {1'b1, 4'd0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_bin <= 4'd0;
            exp_inv <= 1'b0;
        end else begin
            {exp_inv, exp_bin} <= model(aiken);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (exp_bin !== 4'bx) begin
            chk("model_bin", int'(bin), int'(exp_bin));
            chk("model_invalid", int'(invalid), int'(exp_inv));
        end
    end

    task automatic step(input logic [3:0] v);
        aiken = v;
        @(posedge clk);
        #1;
    endtask

    int sweep_bin[16] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 5, 6, 7, 8, 9};
    logic [3:0] legal[10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    logic [3:0] bnd_in[4]  = '{4'b0100, 4'b0101, 4'b1010, 4'b1011};
    int         bnd_bin[4] = '{4, 0, 0, 5};
    int         bnd_inv[4] = '{0, 1, 1, 0};

    initial begin
        int first;
        // Reset with a legal input and the clock running
        rst   = 1'b1;
        aiken = 4'b1111;
        #1;
        chk("reset_bin_immediate", int'(bin), 0);
        chk("reset_inv_immediate", int'(invalid), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_bin_held", int'(bin), 0);
            chk("reset_inv_held", int'(invalid), 0);
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_bin", int'(bin), 9);
        chk("release_inv", int'(invalid), 0);

        // Full sweep
        for (int i = 0; i < 16; i++) begin
            step(4'(i));
            chk("sweep_bin", int'(bin), sweep_bin[i]);
            chk("sweep_inv", int'(invalid), (i >= 5 && i <= 10) ? 1 : 0);
        end

        // Edges of the illegal range
        for (int i = 0; i < 4; i++) begin
            step(bnd_in[i]);
            chk("boundary_bin", int'(bin), bnd_bin[i]);
            chk("boundary_inv", int'(invalid), bnd_inv[i]);
        end

        // Self-complement
        for (int i = 0; i < 10; i++) begin
            step(legal[i]);
            first = int'(bin);
            step(~legal[i]);
            chk("complement_sum", first + int'(bin), 9);
            chk("complement_inv", int'(invalid), 0);
        end

        // Mid-stream async reset
        step(4'b1011);
        chk("stream_5", int'(bin), 5);
        step(4'b1100);
        chk("stream_6", int'(bin), 6);
        aiken = 4'b1101;
        #2 rst = 1'b1;
        #1;
        chk("midreset_bin", int'(bin), 0);
        chk("midreset_inv", int'(invalid), 0);
        @(posedge clk);
        #1;
        chk("midreset_hold_bin", int'(bin), 0);
        #2 rst = 1'b0;
        aiken = 4'b1110;
        @(posedge clk);
        #1;
        chk("resume_bin", int'(bin), 8);
        chk("resume_inv", int'(invalid), 0);

        // Hold steady input
        for (int i = 0; i < 10; i++) begin
            step(4'b1101);
            chk("hold_bin", int'(bin), 7);
            chk("hold_inv", int'(invalid), 0);
        end

        // Mid-cycle input change must not reach the outputs before the edge
        step(4'b0011);
        aiken = 4'b0101;
        #2;
        chk("between_edges_bin", int'(bin), 3);
        chk("between_edges_inv", int'(invalid), 0);
        @(posedge clk);
        #1;
        chk("after_edge_inv", int'(invalid), 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
